// File: rtl/memory_stage_if.sv
// Shared instruction descriptor types and the data-memory bus interface used by
// the memory stage (master) and the data memory (slave).
package memory_stage_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NONE = 2'd0,
      MEM_OP_LW   = 2'd1,
      MEM_OP_SW   = 2'd2,
      MEM_OP_RSVD = 2'd3
   } mem_op_e;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_we;
      mem_op_e    mem_op;
   } f_dec_t;

   typedef struct packed {
      logic [31:0] pc;
      f_dec_t      f_dec;
   } instr_structure;

endpackage

interface memory_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle and runs LW/SW
// accesses on the data-memory bus with misalignment and ack-timeout detection.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  done_in,
   input  instr_structure        ex_iCont,
   input  logic [31:0]           ex_result,
   input  logic [31:0]           ex_storeData,
   output logic                  stall_out,
   memory_stage_if.master        dmem,
   output logic [31:0]           lData,
   output logic [31:0]           result_fromALU,
   output instr_structure        wb_iCont,
   output logic                  done_out,
   output logic                  misalign_err,
   output logic                  bus_err
);

   typedef enum logic {IDLE, ACCESS} state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             we_q, we_d;
   logic [31:0]      lData_q, lData_d;
   logic [31:0]      result_q, result_d;
   instr_structure   pend_q, pend_d;
   instr_structure   wb_q, wb_d;
   logic             done_q, done_d;
   logic             mis_q, mis_d;
   logic             berr_q, berr_d;
   logic             isMem;

   assign isMem = (ex_iCont.f_dec.mem_op == MEM_OP_LW) || (ex_iCont.f_dec.mem_op == MEM_OP_SW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         lData_q  <= '0;
         result_q <= '0;
         pend_q   <= '0;
         wb_q     <= '0;
         done_q   <= 1'b0;
         mis_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         lData_q  <= lData_d;
         result_q <= result_d;
         pend_q   <= pend_d;
         wb_q     <= wb_d;
         done_q   <= done_d;
         mis_q    <= mis_d;
         berr_q   <= berr_d;
      end
   end

   // A memory instruction is parked in pend_q and only reaches the writeback
   // outputs on ack, so those outputs change exactly when done_out pulses.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      lData_d  = lData_q;
      result_d = result_q;
      pend_d   = pend_q;
      wb_d     = wb_q;
      done_d   = 1'b0;
      mis_d    = 1'b0;
      berr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (done_in) begin
               if (!isMem) begin
                  wb_d     = ex_iCont;
                  result_d = ex_result;
                  done_d   = 1'b1;
               end else if (ex_result[1:0] != 2'b00) begin
                  mis_d = 1'b1;
               end else begin
                  pend_d  = ex_iCont;
                  addr_d  = ex_result;
                  we_d    = (ex_iCont.f_dec.mem_op == MEM_OP_SW);
                  wdata_d = ex_storeData;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // Ack wins over the timeout when both land in the last cycle.
            if (dmem.dmem_ack) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               wb_d     = pend_q;
               result_d = addr_q;
               if (!we_q) begin
                  lData_d = dmem.dmem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall_out       = (state_q == ACCESS);
   assign dmem.dmem_req   = (state_q == ACCESS);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign lData           = lData_q;
   assign result_fromALU  = result_q;
   assign wb_iCont        = wb_q;
   assign done_out        = done_q;
   assign misalign_err    = mis_q;
   assign bus_err         = berr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed corner cases then a random
// instruction stream, all scored against a transaction-level reference model.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int NEVER   = 1000;

   typedef struct {
      int             cycle;
      logic [2:0]     pulses;
      int             reqCycles;
      instr_structure instr;
      logic [31:0]    result;
      logic           isLoad;
      logic [31:0]    rdata;
   } expEvent_t;

   logic           clk;
   logic           rst_n;
   logic           done_in;
   instr_structure ex_iCont;
   logic [31:0]    ex_result;
   logic [31:0]    ex_storeData;
   logic           stall_out;
   logic [31:0]    lData;
   logic [31:0]    result_fromALU;
   instr_structure wb_iCont;
   logic           done_out;
   logic           misalign_err;
   logic           bus_err;

   memory_stage_if dmemBus();

   memory_stage #(.ACK_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .done_in        (done_in),
      .ex_iCont       (ex_iCont),
      .ex_result      (ex_result),
      .ex_storeData   (ex_storeData),
      .stall_out      (stall_out),
      .dmem           (dmemBus.master),
      .lData          (lData),
      .result_fromALU (result_fromALU),
      .wb_iCont       (wb_iCont),
      .done_out       (done_out),
      .misalign_err   (misalign_err),
      .bus_err        (bus_err)
   );

   int             vectors     = 0;
   int             miscompares = 0;
   int             cycleCount  = 0;
   int             reqRun      = 0;
   int             waitLeft    = 0;
   int             curDelay    = 0;
   logic           inFlight    = 1'b0;
   logic           idleAckNoise = 1'b0;
   logic [31:0]    curAddr, curWdata, curRdata;
   logic           curWe;
   instr_structure lastWb;
   logic [31:0]    lastResult, lastLData;
   expEvent_t      expQ[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleCount);
      end
   endtask

   // One clock: monitor the DUT against the model, then play the memory side.
   task automatic tick();
      logic [2:0] pulses;
      expEvent_t  e;
      @(posedge clk);
      #1;
      cycleCount++;
      pulses = {done_out, misalign_err, bus_err};
      checkOutput("pulseOneHot", 64'($countones(pulses) > 1), 64'd0);
      checkOutput("stallEqReq", 64'(stall_out), 64'(dmemBus.dmem_req));
      if (dmemBus.dmem_req) begin
         reqRun++;
         checkOutput("dmemAddr", 64'(dmemBus.dmem_addr), 64'(curAddr));
         checkOutput("dmemWe", 64'(dmemBus.dmem_we), 64'(curWe));
         if (curWe) checkOutput("dmemWdata", 64'(dmemBus.dmem_wdata), 64'(curWdata));
      end
      if (pulses != 3'b000) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedPulse", 64'(pulses), 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("pulseKind", 64'(pulses), 64'(e.pulses));
            checkOutput("pulseCycle", 64'(cycleCount), 64'(e.cycle));
            checkOutput("reqCycles", 64'(reqRun), 64'(e.reqCycles));
            reqRun = 0;
            if (e.pulses == 3'b100) begin
               lastWb     = e.instr;
               lastResult = e.result;
               if (e.isLoad) lastLData = e.rdata;
            end
         end
      end
      checkOutput("wbICont", 64'(wb_iCont), 64'(lastWb));
      checkOutput("resultFromAlu", 64'(result_fromALU), 64'(lastResult));
      checkOutput("lData", 64'(lData), 64'(lastLData));
      if (dmemBus.dmem_req) begin
         if (!inFlight) begin
            inFlight = 1'b1;
            waitLeft = curDelay;
         end
         dmemBus.dmem_ack   = (waitLeft == 0);
         dmemBus.dmem_rdata = (waitLeft == 0) ? curRdata : $urandom;
         waitLeft--;
      end else begin
         inFlight           = 1'b0;
         dmemBus.dmem_ack   = idleAckNoise ? 1'($urandom_range(0, 1)) : 1'b0;
         dmemBus.dmem_rdata = $urandom;
      end
   endtask

   task automatic applyIdle(input int n);
      done_in = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present one instruction, predict its outcome, and hold it while stalled.
   task automatic applyStimulus(input mem_op_e op, input logic [31:0] addr,
                                input logic [31:0] sdata, input int delay);
      expEvent_t e;
      logic      isMem, isMis;
      int        lat;
      isMem = (op == MEM_OP_LW) || (op == MEM_OP_SW);
      isMis = isMem && (addr % 4 != 0);
      e.instr.pc            = $urandom;
      e.instr.f_dec.rd      = 5'($urandom);
      e.instr.f_dec.reg_we  = (op != MEM_OP_SW);
      e.instr.f_dec.mem_op  = op;
      e.result              = addr;
      e.isLoad              = (op == MEM_OP_LW);
      e.rdata               = $urandom;
      lat                   = (isMem && !isMis) ? ((delay < TIMEOUT) ? delay + 1 : TIMEOUT) : 0;
      e.cycle               = cycleCount + 1 + lat;
      e.reqCycles           = lat;
      if (isMis)                                e.pulses = 3'b010;
      else if (isMem && delay >= TIMEOUT)       e.pulses = 3'b001;
      else                                      e.pulses = 3'b100;
      expQ.push_back(e);
      curAddr  = addr;
      curWe    = (op == MEM_OP_SW);
      curWdata = sdata;
      curDelay = delay;
      curRdata = e.rdata;
      done_in      = 1'b1;
      ex_iCont     = e.instr;
      ex_result    = addr;
      ex_storeData = sdata;
      tick();
      for (int g = 0; g < 40 && stall_out; g++) tick();
      if (stall_out) checkOutput("stallStuck", 64'(stall_out), 64'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      done_in      = 1'b0;
      ex_iCont     = '0;
      ex_result    = '0;
      ex_storeData = '0;
      dmemBus.dmem_ack   = 1'b0;
      dmemBus.dmem_rdata = '0;
      curAddr = '0; curWdata = '0; curRdata = '0; curWe = 1'b0;
      lastWb = '0; lastResult = '0; lastLData = '0;

      #3;
      checkOutput("rstStall", 64'(stall_out), 64'd0);
      checkOutput("rstReq", 64'(dmemBus.dmem_req), 64'd0);
      checkOutput("rstWe", 64'(dmemBus.dmem_we), 64'd0);
      checkOutput("rstAddr", 64'(dmemBus.dmem_addr), 64'd0);
      checkOutput("rstWdata", 64'(dmemBus.dmem_wdata), 64'd0);
      checkOutput("rstDone", 64'(done_out), 64'd0);
      checkOutput("rstMisalign", 64'(misalign_err), 64'd0);
      checkOutput("rstBusErr", 64'(bus_err), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      applyStimulus(MEM_OP_NONE, 32'h0000_1234, 32'h0, 0);
      applyIdle(2);
      applyStimulus(MEM_OP_LW, 32'h0000_0100, 32'h0, 3);
      applyIdle(2);
      applyStimulus(MEM_OP_SW, 32'h0000_0104, 32'h55AA_55AA, 0);
      applyIdle(2);
      applyStimulus(MEM_OP_LW, 32'h0000_0102, 32'h0, 0);
      applyIdle(2);
      applyStimulus(MEM_OP_LW, 32'h0000_0200, 32'h0, NEVER);
      applyIdle(2);
      applyStimulus(MEM_OP_LW, 32'h0000_0204, 32'h0, TIMEOUT - 1);
      applyIdle(2);

      // Reset lands in the second ACCESS cycle of a load that never gets acked.
      curAddr  = 32'h0000_0300;
      curWe    = 1'b0;
      curDelay = NEVER;
      ex_iCont.f_dec.mem_op = MEM_OP_LW;
      ex_result = 32'h0000_0300;
      done_in   = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midResetReq", 64'(dmemBus.dmem_req), 64'd0);
      checkOutput("midResetStall", 64'(stall_out), 64'd0);
      done_in    = 1'b0;
      lastWb     = '0;
      lastResult = '0;
      lastLData  = '0;
      reqRun     = 0;
      tick();
      tick();
      rst_n = 1'b1;
      applyIdle(5);

      applyStimulus(MEM_OP_LW, 32'h0000_0400, 32'h0, 1);
      applyStimulus(MEM_OP_SW, 32'h0000_0408, 32'hCAFE_F00D, 2);
      applyIdle(2);

      idleAckNoise = 1'b1;
      for (int n = 0; n < 150; n++) begin
         mem_op_e     op;
         logic [31:0] addr;
         int          r, delay;
         op   = mem_op_e'($urandom_range(0, 2));
         addr = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
         r = $urandom_range(0, 9);
         if (r <= 6)      delay = $urandom_range(0, 4);
         else if (r == 7) delay = TIMEOUT - 1;
         else if (r == 8) delay = NEVER;
         else             delay = TIMEOUT - 2;
         applyStimulus(op, addr, $urandom, delay);
         if ($urandom_range(0, 9) < 3) begin
            ex_result    = $urandom;
            ex_storeData = $urandom;
            applyIdle($urandom_range(1, 3));
         end
      end

      done_in = 1'b0;
      for (int g = 0; g < 40 && expQ.size() > 0; g++) tick();
      checkOutput("pendingEvents", 64'(expQ.size()), 64'd0);
      applyIdle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
